ifu_fetch: RTL

// Multi-cycle instruction fetch stage. It replaces the combinational pmem_read fetch with a

---
 rtl/ifu_fetch.sv | 83 ++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch: registered PC, AXI4-Lite AR/R master, valid/ready hand-off to IDU.
// One instruction in flight; the next fetch starts only after WBU commits with dnpc.
module ifu_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  input  logic              commit,
  input  logic [ADDR_W-1:0] next_pc,
  output logic              fetch_err,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, EXEC} state_t;

  state_t state, state_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_n;
  end

  // Handshake outputs decode from registered state only, so nothing combinational
  // leaks from the bus inputs back onto arvalid/rready/inst_valid.
  always_comb begin
    state_n    = state;
    arvalid    = 1'b0;
    rready     = 1'b0;
    inst_valid = 1'b0;
    case (state)
      BOOT: state_n = REQ;
      REQ: begin
        arvalid = 1'b1;
        if (arready) state_n = WAIT;
      end
      WAIT: begin
        rready = 1'b1;
        if (rvalid) state_n = HOLD;
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) state_n = EXEC;
      end
      EXEC: if (commit) state_n = REQ;
      default: state_n = BOOT;
    endcase
  end

  assign araddr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      inst      <= '0;
      fetch_err <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      if (state == WAIT && rvalid) begin
        // A faulted read hands a zero word to decode; the error is only recorded.
        inst <= (rresp == 2'b00) ? rdata : 32'h0;
        if (rresp != 2'b00) fetch_err <= 1'b1;
      end
      if (state == HOLD && inst_ready) fetch_cnt <= fetch_cnt + 32'd1;
      if (state == EXEC && commit) begin
        pc <= {next_pc[ADDR_W-1:2], 2'b00};
        if (next_pc[1:0] != 2'b00) fetch_err <= 1'b1;
      end
    end
  end

endmodule
